// File: rtl/ahbl_pkg.sv
// Shared AHB-Lite definitions for the 2:1 arbiter slice.
//   htrans_e : HTRANS encodings (IDLE, BUSY, NONSEQ, SEQ)
//   owner_e  : data-phase owner encoding (NONE, M0, M1)
package ahbl_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  typedef enum logic [1:0] {
    OWN_NONE = 2'b00,
    OWN_M0   = 2'b01,
    OWN_M1   = 2'b10
  } owner_e;

endpackage

// File: rtl/ahbl_aphase_buf.sv
// One-entry address-phase holding buffer, one per master.
// Ports:
//   clk, rst_n      : clock, async active-low reset
//   capture         : load d_* and set valid (live request that lost arbitration)
//   clear           : drop the held entry (held entry was granted)
//   d_*             : live address-phase fields from the master
//   valid           : an entry is held
//   q_*             : held address-phase fields
// capture and clear are never asserted together: a master with a held entry
// sees hready=0, so it cannot present a live request at the same time.
module ahbl_aphase_buf #(
  parameter int W_ADDR = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              capture,
  input  logic              clear,
  input  logic [W_ADDR-1:0] d_haddr,
  input  logic              d_hwrite,
  input  logic [2:0]        d_hsize,
  input  logic [2:0]        d_hburst,
  input  logic [3:0]        d_hprot,
  input  logic              d_hmastlock,
  output logic              valid,
  output logic [W_ADDR-1:0] q_haddr,
  output logic              q_hwrite,
  output logic [2:0]        q_hsize,
  output logic [2:0]        q_hburst,
  output logic [3:0]        q_hprot,
  output logic              q_hmastlock
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid       <= 1'b0;
      q_haddr     <= '0;
      q_hwrite    <= 1'b0;
      q_hsize     <= '0;
      q_hburst    <= '0;
      q_hprot     <= '0;
      q_hmastlock <= 1'b0;
    end else if (capture) begin
      valid       <= 1'b1;
      q_haddr     <= d_haddr;
      q_hwrite    <= d_hwrite;
      q_hsize     <= d_hsize;
      q_hburst    <= d_hburst;
      q_hprot     <= d_hprot;
      q_hmastlock <= d_hmastlock;
    end else if (clear) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/ahbl_arbiter_2to1.sv
// Two-master to one-slave AHB-Lite arbiter.
// Ports:
//   clk, rst_n                 : clock, async active-low reset
//   m0_*/m1_* h{addr,write,trans,size,burst,prot,mastlock,wdata} : master side in
//   m0_*/m1_* h{ready,resp,rdata} : master side out
//   s_* h{addr,write,trans,size,burst,prot,mastlock,wdata,ready} : slave side out
//   s_hready_resp, s_hresp, s_hrdata : slave response in
//   dbg_dph_owner              : current data-phase owner (owner_e)
// Handshake: an address phase of master i is accepted when mi_hready=1 and
// htrans is NONSEQ/SEQ at the rising edge; it is forwarded to the slave only
// in cycles where s_hready_resp=1. Anything accepted but not forwarded is held
// and the master is stalled (mi_hready=0) until the held entry is issued.
import ahbl_pkg::*;

module ahbl_arbiter_2to1 #(
  parameter int W_ADDR = 32,
  parameter int W_DATA = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [W_ADDR-1:0] m0_haddr,
  input  logic              m0_hwrite,
  input  logic [1:0]        m0_htrans,
  input  logic [2:0]        m0_hsize,
  input  logic [2:0]        m0_hburst,
  input  logic [3:0]        m0_hprot,
  input  logic              m0_hmastlock,
  input  logic [W_DATA-1:0] m0_hwdata,
  output logic              m0_hready,
  output logic              m0_hresp,
  output logic [W_DATA-1:0] m0_hrdata,
  input  logic [W_ADDR-1:0] m1_haddr,
  input  logic              m1_hwrite,
  input  logic [1:0]        m1_htrans,
  input  logic [2:0]        m1_hsize,
  input  logic [2:0]        m1_hburst,
  input  logic [3:0]        m1_hprot,
  input  logic              m1_hmastlock,
  input  logic [W_DATA-1:0] m1_hwdata,
  output logic              m1_hready,
  output logic              m1_hresp,
  output logic [W_DATA-1:0] m1_hrdata,
  output logic [W_ADDR-1:0] s_haddr,
  output logic              s_hwrite,
  output logic [1:0]        s_htrans,
  output logic [2:0]        s_hsize,
  output logic [2:0]        s_hburst,
  output logic [3:0]        s_hprot,
  output logic              s_hmastlock,
  output logic [W_DATA-1:0] s_hwdata,
  output logic              s_hready,
  input  logic              s_hready_resp,
  input  logic              s_hresp,
  input  logic [W_DATA-1:0] s_hrdata,
  output logic [1:0]        dbg_dph_owner
);

  owner_e dph_owner, dph_owner_nxt;
  logic   rr_m1;        // 1: contention goes to M1
  logic   lock_active;
  logic   lock_m1;      // which master holds the lock
  logic   live0, live1, cand0, cand1, gnt0, gnt1, arb_en;

  logic              held0, held1;
  logic [W_ADDR-1:0] b0_haddr, b1_haddr;
  logic              b0_hwrite, b1_hwrite, b0_hmastlock, b1_hmastlock;
  logic [2:0]        b0_hsize, b1_hsize, b0_hburst, b1_hburst;
  logic [3:0]        b0_hprot, b1_hprot;

  ahbl_aphase_buf #(.W_ADDR(W_ADDR)) u_buf0 (
    .clk(clk), .rst_n(rst_n), .capture(live0 & ~gnt0), .clear(held0 & gnt0),
    .d_haddr(m0_haddr), .d_hwrite(m0_hwrite), .d_hsize(m0_hsize),
    .d_hburst(m0_hburst), .d_hprot(m0_hprot), .d_hmastlock(m0_hmastlock),
    .valid(held0), .q_haddr(b0_haddr), .q_hwrite(b0_hwrite), .q_hsize(b0_hsize),
    .q_hburst(b0_hburst), .q_hprot(b0_hprot), .q_hmastlock(b0_hmastlock)
  );

  ahbl_aphase_buf #(.W_ADDR(W_ADDR)) u_buf1 (
    .clk(clk), .rst_n(rst_n), .capture(live1 & ~gnt1), .clear(held1 & gnt1),
    .d_haddr(m1_haddr), .d_hwrite(m1_hwrite), .d_hsize(m1_hsize),
    .d_hburst(m1_hburst), .d_hprot(m1_hprot), .d_hmastlock(m1_hmastlock),
    .valid(held1), .q_haddr(b1_haddr), .q_hwrite(b1_hwrite), .q_hsize(b1_hsize),
    .q_hburst(b1_hburst), .q_hprot(b1_hprot), .q_hmastlock(b1_hmastlock)
  );

  // Master-side ready depends only on registered state and s_hready_resp,
  // so the live-request terms below form no combinational loop.
  always_comb begin
    m0_hready = 1'b1;
    m1_hready = 1'b1;
    if (held0)                   m0_hready = 1'b0;
    else if (dph_owner == OWN_M0) m0_hready = s_hready_resp;
    if (held1)                   m1_hready = 1'b0;
    else if (dph_owner == OWN_M1) m1_hready = s_hready_resp;
  end

  assign live0 = m0_hready && ((m0_htrans == HTRANS_NONSEQ) || (m0_htrans == HTRANS_SEQ));
  assign live1 = m1_hready && ((m1_htrans == HTRANS_NONSEQ) || (m1_htrans == HTRANS_SEQ));
  assign cand0 = held0 | live0;
  assign cand1 = held1 | live1;
  // Gating with rst_n keeps the slave bus idle while reset is asserted.
  assign arb_en = s_hready_resp & rst_n;

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (arb_en) begin
      if (lock_active) begin
        if (lock_m1) gnt1 = cand1;
        else         gnt0 = cand0;
      end else if (cand0 && cand1) begin
        if (rr_m1) gnt1 = 1'b1;
        else       gnt0 = 1'b1;
      end else begin
        gnt0 = cand0;
        gnt1 = cand1;
      end
    end
  end

  // Every grant goes out as NONSEQ: transfers of the two masters may
  // interleave, so a master's SEQ is not sequential from the slave's view.
  always_comb begin
    s_haddr     = '0;
    s_hwrite    = 1'b0;
    s_htrans    = HTRANS_IDLE;
    s_hsize     = '0;
    s_hburst    = '0;
    s_hprot     = '0;
    s_hmastlock = 1'b0;
    if (gnt0) begin
      s_htrans    = HTRANS_NONSEQ;
      s_haddr     = held0 ? b0_haddr     : m0_haddr;
      s_hwrite    = held0 ? b0_hwrite    : m0_hwrite;
      s_hsize     = held0 ? b0_hsize     : m0_hsize;
      s_hburst    = held0 ? b0_hburst    : m0_hburst;
      s_hprot     = held0 ? b0_hprot     : m0_hprot;
      s_hmastlock = held0 ? b0_hmastlock : m0_hmastlock;
    end else if (gnt1) begin
      s_htrans    = HTRANS_NONSEQ;
      s_haddr     = held1 ? b1_haddr     : m1_haddr;
      s_hwrite    = held1 ? b1_hwrite    : m1_hwrite;
      s_hsize     = held1 ? b1_hsize     : m1_hsize;
      s_hburst    = held1 ? b1_hburst    : m1_hburst;
      s_hprot     = held1 ? b1_hprot     : m1_hprot;
      s_hmastlock = held1 ? b1_hmastlock : m1_hmastlock;
    end
  end

  always_comb begin
    dph_owner_nxt = dph_owner;
    if (s_hready_resp) begin
      if (gnt0)      dph_owner_nxt = OWN_M0;
      else if (gnt1) dph_owner_nxt = OWN_M1;
      else           dph_owner_nxt = OWN_NONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dph_owner   <= OWN_NONE;
      rr_m1       <= 1'b0;
      lock_active <= 1'b0;
      lock_m1     <= 1'b0;
    end else begin
      dph_owner <= dph_owner_nxt;
      if (gnt0 || gnt1) begin
        rr_m1       <= gnt0;         // favour the master not just granted
        lock_active <= s_hmastlock;  // a lock=0 grant releases the lock
        lock_m1     <= gnt1;
      end
    end
  end

  always_comb begin
    case (dph_owner)
      OWN_M0:  s_hwdata = m0_hwdata;
      OWN_M1:  s_hwdata = m1_hwdata;
      default: s_hwdata = '0;
    endcase
  end

  assign m0_hresp      = (dph_owner == OWN_M0) ? s_hresp : 1'b0;
  assign m1_hresp      = (dph_owner == OWN_M1) ? s_hresp : 1'b0;
  assign m0_hrdata     = s_hrdata;
  assign m1_hrdata     = s_hrdata;
  assign s_hready      = s_hready_resp;
  assign dbg_dph_owner = dph_owner;

endmodule

// File: tb/tb_ahbl_arbiter_2to1.sv
// Directed bench for ahbl_arbiter_2to1. Issue order on the slave bus is
// checked by a monitor against an expected-address queue; per-cycle ready,
// response and write-data values are checked inline against hand-derived
// constants.
module tb_ahbl_arbiter_2to1;
  import ahbl_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [AW-1:0] m0_haddr, m1_haddr, s_haddr;
  logic          m0_hwrite, m1_hwrite, s_hwrite;
  logic [1:0]    m0_htrans, m1_htrans, s_htrans;
  logic [2:0]    m0_hsize, m1_hsize, s_hsize, m0_hburst, m1_hburst, s_hburst;
  logic [3:0]    m0_hprot, m1_hprot, s_hprot;
  logic          m0_hmastlock, m1_hmastlock, s_hmastlock;
  logic [DW-1:0] m0_hwdata, m1_hwdata, s_hwdata;
  logic          m0_hready, m1_hready, s_hready;
  logic          m0_hresp, m1_hresp;
  logic [DW-1:0] m0_hrdata, m1_hrdata;
  logic          s_hready_resp, s_hresp;
  logic [DW-1:0] s_hrdata;
  logic [1:0]    dbg_dph_owner;

  ahbl_arbiter_2to1 #(.W_ADDR(AW), .W_DATA(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_haddr(m0_haddr), .m0_hwrite(m0_hwrite), .m0_htrans(m0_htrans),
    .m0_hsize(m0_hsize), .m0_hburst(m0_hburst), .m0_hprot(m0_hprot),
    .m0_hmastlock(m0_hmastlock), .m0_hwdata(m0_hwdata),
    .m0_hready(m0_hready), .m0_hresp(m0_hresp), .m0_hrdata(m0_hrdata),
    .m1_haddr(m1_haddr), .m1_hwrite(m1_hwrite), .m1_htrans(m1_htrans),
    .m1_hsize(m1_hsize), .m1_hburst(m1_hburst), .m1_hprot(m1_hprot),
    .m1_hmastlock(m1_hmastlock), .m1_hwdata(m1_hwdata),
    .m1_hready(m1_hready), .m1_hresp(m1_hresp), .m1_hrdata(m1_hrdata),
    .s_haddr(s_haddr), .s_hwrite(s_hwrite), .s_htrans(s_htrans),
    .s_hsize(s_hsize), .s_hburst(s_hburst), .s_hprot(s_hprot),
    .s_hmastlock(s_hmastlock), .s_hwdata(s_hwdata), .s_hready(s_hready),
    .s_hready_resp(s_hready_resp), .s_hresp(s_hresp), .s_hrdata(s_hrdata),
    .dbg_dph_owner(dbg_dph_owner)
  );

  // ---------------- scoreboard ----------------
  logic [AW-1:0] exp_q[$];
  logic [AW-1:0] mon_exp;
  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every address phase presented to the slave pops one entry.
  always @(negedge clk) begin
    if (rst_n && s_htrans != 2'b00) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_issue: got s_haddr 0x%0h expected no issue at %0t", s_haddr, $time);
      end else begin
        mon_exp = exp_q.pop_front();
        chk("issue_addr", {32'h0, s_haddr}, {32'h0, mon_exp});
        chk("issue_htrans", {62'h0, s_htrans}, 64'h2);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic drv(input int m, input logic [1:0] tr, input logic [31:0] a,
                     input logic w, input logic lk);
    if (m == 0) begin
      m0_htrans = tr; m0_haddr = a; m0_hwrite = w; m0_hmastlock = lk;
    end else begin
      m1_htrans = tr; m1_haddr = a; m1_hwrite = w; m1_hmastlock = lk;
    end
  endtask

  task automatic idle(input int m);
    drv(m, 2'b00, 32'h0, 1'b0, 1'b0);
  endtask

  // Burst-contention table: M1 SEQ burst 0x40..0x4C against M0 singles.
  logic [1:0]  c_tr1  [7] = '{2'b10, 2'b11, 2'b11, 2'b11, 2'b11, 2'b11, 2'b00};
  logic [31:0] c_a1   [7] = '{32'h40, 32'h44, 32'h48, 32'h48, 32'h4C, 32'h4C, 32'h0};
  logic [1:0]  c_tr0  [7] = '{2'b00, 2'b10, 2'b10, 2'b10, 2'b10, 2'b00, 2'b00};
  logic [31:0] c_a0   [7] = '{32'h0, 32'h200, 32'h204, 32'h208, 32'h208, 32'h0, 32'h0};
  logic        c_rdy0 [7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
  logic        c_rdy1 [7] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

  initial begin
    m0_hsize = 3'b010; m1_hsize = 3'b010;
    m0_hburst = 3'b000; m1_hburst = 3'b000;
    m0_hprot = 4'h3; m1_hprot = 4'h3;
    m0_hwdata = 32'hAAAA; m1_hwdata = 32'h0;
    s_hready_resp = 1'b1; s_hresp = 1'b0; s_hrdata = 32'h0;
    idle(1);
    drv(0, 2'b10, 32'h999, 1'b0, 1'b0);   // request while in reset

    // Reset state
    smp();
    chk("rst_s_htrans", {62'h0, s_htrans}, 64'h0);
    chk("rst_m0_hready", {63'h0, m0_hready}, 64'h1);
    chk("rst_m1_hready", {63'h0, m1_hready}, 64'h1);
    chk("rst_m0_hresp", {63'h0, m0_hresp}, 64'h0);
    chk("rst_s_hwdata", {32'h0, s_hwdata}, 64'h0);
    chk("rst_owner", {62'h0, dbg_dph_owner}, 64'h0);
    idle(0);
    m0_hwdata = 32'h0;
    step(); step();
    rst_n = 1'b1;

    // Single M0 read, zero-wait slave
    step(); drv(0, 2'b10, 32'h100, 1'b0, 1'b0); exp_q.push_back(32'h100);
    smp(); chk("a_m0_hready_ap", {63'h0, m0_hready}, 64'h1);
    step(); idle(0); s_hrdata = 32'hCAFE0001;
    smp();
    chk("a_m0_hready_dp", {63'h0, m0_hready}, 64'h1);
    chk("a_m0_hrdata", {32'h0, m0_hrdata}, 64'hCAFE0001);
    chk("a_m1_hrdata", {32'h0, m1_hrdata}, 64'hCAFE0001);
    chk("a_owner", {62'h0, dbg_dph_owner}, 64'h1);
    step();
    rst_n = 1'b0; step(); rst_n = 1'b1;

    // Simultaneous writes after reset: M0 first, M1 held one cycle
    step(); drv(0, 2'b10, 32'h10, 1'b1, 1'b0); drv(1, 2'b10, 32'h20, 1'b1, 1'b0);
    exp_q.push_back(32'h10); exp_q.push_back(32'h20);
    smp(); chk("b_m1_hready_ap", {63'h0, m1_hready}, 64'h1);
    step(); idle(0); idle(1); m0_hwdata = 32'hD0; m1_hwdata = 32'hD1;
    smp();
    chk("b_m1_hready_held", {63'h0, m1_hready}, 64'h0);
    chk("b_s_hwdata_m0", {32'h0, s_hwdata}, 64'hD0);
    step(); m0_hwdata = 32'h0;
    smp();
    chk("b_s_hwdata_m1", {32'h0, s_hwdata}, 64'hD1);
    chk("b_m1_hready_dp", {63'h0, m1_hready}, 64'h1);
    m1_hwdata = 32'h0;

    // M1 burst vs M0 contention: grants alternate M1/M0, all NONSEQ
    exp_q.push_back(32'h40);  exp_q.push_back(32'h200);
    exp_q.push_back(32'h44);  exp_q.push_back(32'h204);
    exp_q.push_back(32'h48);  exp_q.push_back(32'h208);
    exp_q.push_back(32'h4C);
    for (int i = 0; i < 7; i++) begin
      step();
      drv(1, c_tr1[i], c_a1[i], 1'b0, 1'b0);
      drv(0, c_tr0[i], c_a0[i], 1'b0, 1'b0);
      smp();
      chk($sformatf("c_m0_hready[%0d]", i), {63'h0, m0_hready}, {63'h0, c_rdy0[i]});
      chk($sformatf("c_m1_hready[%0d]", i), {63'h0, m1_hready}, {63'h0, c_rdy1[i]});
    end
    step();

    // Three slave wait states on M0; M1 request during stall is held
    step(); drv(0, 2'b10, 32'h300, 1'b0, 1'b0);
    exp_q.push_back(32'h300); exp_q.push_back(32'h40);
    smp(); chk("d_m0_hready_ap", {63'h0, m0_hready}, 64'h1);
    step(); idle(0); drv(1, 2'b10, 32'h40, 1'b0, 1'b0); s_hready_resp = 1'b0;
    smp();
    chk("d_m0_hready_w1", {63'h0, m0_hready}, 64'h0);
    chk("d_m1_hready_w1", {63'h0, m1_hready}, 64'h1);
    chk("d_s_htrans_w1", {62'h0, s_htrans}, 64'h0);
    step(); idle(1); s_hresp = 1'b1;
    smp();
    chk("d_m1_hready_w2", {63'h0, m1_hready}, 64'h0);
    chk("d_m0_hresp_w2", {63'h0, m0_hresp}, 64'h1);
    chk("d_m1_hresp_w2", {63'h0, m1_hresp}, 64'h0);
    chk("d_s_htrans_w2", {62'h0, s_htrans}, 64'h0);
    step(); s_hresp = 1'b0;
    smp();
    chk("d_m1_hready_w3", {63'h0, m1_hready}, 64'h0);
    chk("d_s_htrans_w3", {62'h0, s_htrans}, 64'h0);
    step(); s_hready_resp = 1'b1;
    smp();
    chk("d_m0_hready_done", {63'h0, m0_hready}, 64'h1);
    chk("d_m1_hready_issue", {63'h0, m1_hready}, 64'h0);
    step();
    smp();
    chk("d_m1_hready_dp", {63'h0, m1_hready}, 64'h1);
    chk("d_owner", {62'h0, dbg_dph_owner}, 64'h2);

    // Locked M0 sequence: M1 waits until M0 issues hmastlock=0
    step(); drv(0, 2'b10, 32'h500, 1'b0, 1'b1); drv(1, 2'b10, 32'h600, 1'b0, 1'b0);
    exp_q.push_back(32'h500); exp_q.push_back(32'h504);
    exp_q.push_back(32'h508); exp_q.push_back(32'h600);
    smp(); chk("e_m1_hready_ap", {63'h0, m1_hready}, 64'h1);
    step(); drv(0, 2'b10, 32'h504, 1'b0, 1'b1); idle(1);
    smp(); chk("e_m1_hready_l1", {63'h0, m1_hready}, 64'h0);
    step(); drv(0, 2'b10, 32'h508, 1'b0, 1'b0);
    smp(); chk("e_m1_hready_l2", {63'h0, m1_hready}, 64'h0);
    step(); idle(0);
    smp(); chk("e_m1_hready_iss", {63'h0, m1_hready}, 64'h0);
    step();
    smp(); chk("e_m1_hready_dp", {63'h0, m1_hready}, 64'h1);

    // Reset with M1 held and M0 owning the data phase: nothing replays
    step(); drv(0, 2'b10, 32'h700, 1'b1, 1'b0); drv(1, 2'b10, 32'h800, 1'b1, 1'b0);
    exp_q.push_back(32'h700);
    smp(); chk("f_m1_hready_ap", {63'h0, m1_hready}, 64'h1);
    step(); idle(0); idle(1); m0_hwdata = 32'h77;
    #1;
    chk("f_m1_hready_held", {63'h0, m1_hready}, 64'h0);
    chk("f_owner_pre", {62'h0, dbg_dph_owner}, 64'h1);
    rst_n = 1'b0;
    #1;
    chk("f_rst_s_htrans", {62'h0, s_htrans}, 64'h0);
    chk("f_rst_m0_hready", {63'h0, m0_hready}, 64'h1);
    chk("f_rst_m1_hready", {63'h0, m1_hready}, 64'h1);
    chk("f_rst_s_hwdata", {32'h0, s_hwdata}, 64'h0);
    chk("f_rst_owner", {62'h0, dbg_dph_owner}, 64'h0);
    step(); step();
    rst_n = 1'b1;
    repeat (3) step();
    smp();
    chk("f_post_m1_hready", {63'h0, m1_hready}, 64'h1);
    chk("f_post_s_htrans", {62'h0, s_htrans}, 64'h0);

    step();
    chk("exp_q_empty", 64'(exp_q.size()), 64'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/ahbl_arbiter_2to1.md
AHBL_ARBITER_2TO1 -- requirements
Module: ahbl_arbiter_2to1

Interface
REQ-001 Parameter W_ADDR, default 32: address width, all ports.
REQ-002 Parameter W_DATA, default 32: data width, all ports.
REQ-003 clk  input  1  clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  reset: asynchronous, active-low.
REQ-005 m0_/m1_ haddr, hwrite, htrans, hsize, hburst, hprot, hmastlock  input  W_ADDR,1,2,3,3,4,1  master address phase.
REQ-006 m0_/m1_ hwdata  input  W_DATA  master write data.
REQ-007 m0_/m1_ hready  output  1  per-master transfer-done/stall.
REQ-008 m0_/m1_ hresp  output  1  per-master error response.
REQ-009 m0_/m1_ hrdata  output  W_DATA  read data, copy of s_hrdata to both.
REQ-010 s_ haddr, hwrite, htrans, hsize, hburst, hprot, hmastlock  output  same widths  slave address phase.
REQ-011 s_hwdata  output  W_DATA  write data of data-phase owner.
REQ-012 s_hready  output  1  slave hready input; equals s_hready_resp.
REQ-013 s_hready_resp, s_hresp  input  1,1  slave response.
REQ-014 s_hrdata  input  W_DATA  slave read data.

Function
REQ-015 Per master: one-entry aphase buffer (held_i, captured aphase fields) and data-phase ownership register dph_owner in {NONE, M0, M1}.
REQ-016 Master i live request: mi_hready=1 and mi_htrans[1]=1 in same cycle.
REQ-017 Master i candidate: held_i=1 (buffer), else live request.
REQ-018 Arbitration only when s_hready_resp=1; one candidate granted; contention granted by round-robin pointer rr (favours master not most recently granted).
REQ-019 Lock: after grant with hmastlock=1, only that master may be granted until it is granted an aphase with hmastlock=0.
REQ-020 Granted fields drive s_ aphase outputs; s_htrans=2'b10 (NONSEQ) for every grant, since transfers may interleave; no grant: s_htrans=2'b00.
REQ-021 Live request not granted is captured into held_i at the clock edge; granted held entry clears at the clock edge.
REQ-022 When s_hready_resp=1 with a grant, dph_owner updates to granted master next cycle; with no grant, it becomes NONE.
REQ-023 mi_hready = 0 if held_i; else s_hready_resp if dph_owner=i; else 1.
REQ-024 mi_hresp = s_hresp if dph_owner=i, else 0.
REQ-025 s_hwdata = hwdata of dph_owner; zero when NONE.
REQ-026 Latency: uncontended live request reaches slave same cycle (zero added cycles); buffered request costs at least 1 cycle.
REQ-027 Live request while slave stalls (s_hready_resp=0, non-owner) is buffered, not lost.
REQ-028 Owner may present live aphase in final dphase cycle; if it wins, back-to-back issue with no bubble.
REQ-029 held_i and live request of master i never coexist (mi_hready=0 while held).
REQ-030 Uncontended bound: held request issues within 1 slave-ready cycle; lock-free contention: within 2 grants.

Reset
REQ-031 Async reset: held_0=held_1=0, dph_owner=NONE, rr favours M0, lock clear.
REQ-032 During reset: m0/m1 hready=1, hresp=0; s_htrans=2'b00; s_hwdata=0.
REQ-033 Reset mid-transfer discards buffered requests and in-flight ownership; no replay.

Structure
REQ-034 Shared ahbl_pkg holds HTRANS encodings (IDLE, BUSY, NONSEQ, SEQ) and owner encoding.
REQ-035 Sub-module ahbl_aphase_buf: one-entry capture/hold of aphase fields plus valid, instantiated per master.

Verification
REQ-036 Single M0 read 0x100 while M1 idle, slave zero-wait -> s_haddr=0x100 same cycle, m0_hready=1 next cycle, m0_hrdata=s_hrdata.
REQ-037 M0 write 0x10 and M1 write 0x20 same cycle, after reset -> M0 first, M1 held, m1_hready=0 one cycle, then s_haddr=0x20, s_hwdata=m1_hwdata.
REQ-038 M1 SEQ burst of 4 interleaved with M0 -> every s_htrans=2'b10, grants alternate M1/M0 under contention.
REQ-039 Slave inserts 3 wait states on M0 word; M1 requests 0x40 during stall -> M1 held, m1_hready=0, issued on first s_hready_resp=1 cycle.
REQ-040 M0 hmastlock=1 for two transfers, M1 requesting throughout -> M1 not granted until M0 issues hmastlock=0.
REQ-041 rst_n asserted with M1 held and M0 owning dphase -> held cleared, all hready=1, s_htrans=0 immediately.
